// File: rtl/shift_sequencer_pkg.sv
// ============================================================================
// Package : shift_sequencer_pkg
// Op codes and FSM state encoding shared by the shift sequencer files.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package shift_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_SHR  = 3'd0,
    OP_SHRA = 3'd1,
    OP_SHL  = 3'd2,
    OP_ROR  = 3'd3,
    OP_ROL  = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Codes above OP_ROL are reserved and pass the operand through untouched.
  function automatic logic is_reserved(input logic [2:0] op);
    return op > 3'(OP_ROL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_sequencer_if.sv
// ============================================================================
// Interface : shift_sequencer_if
// Start/operand request and busy/done/result response of the shift sequencer.
// Rev       : 1.0
// ============================================================================
`default_nettype none

interface shift_sequencer_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [2:0]           op;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   Z;

  modport master (output start, op, A, B, input busy, done, Z);
  modport slave  (input start, op, A, B, output busy, done, Z);
endinterface

`default_nettype wire

// File: rtl/shift_sequencer_step.sv
// ============================================================================
// Module : shift_sequencer_step
// Combinational single step: shift or rotate i_acc by i_k bits per i_op.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module shift_sequencer_step
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int KW    = 5
) (
  input  wire logic [WIDTH-1:0] i_acc,
  input  wire logic [2:0]       i_op,
  input  wire logic [KW-1:0]    i_k,
  output logic      [WIDTH-1:0] o_acc
);

  // Rotates are taken from a doubled copy so wrapped bits fall into place.
  logic [2*WIDTH-1:0] w_dbl;
  assign w_dbl = {i_acc, i_acc};

  always_comb begin
    o_acc = i_acc;
    case (i_op)
      OP_SHR:  o_acc = i_acc >> i_k;
      OP_SHRA: o_acc = $unsigned($signed(i_acc) >>> i_k);
      OP_SHL:  o_acc = i_acc << i_k;
      OP_ROR:  o_acc = WIDTH'(w_dbl >> i_k);
      OP_ROL:  o_acc = WIDTH'((w_dbl << i_k) >> WIDTH);
      default: o_acc = i_acc;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ============================================================================
// Module : shift_sequencer
// Multi-cycle SHR/SHRA/SHL/ROR/ROL engine moving up to STEP bits per clock.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input wire logic          clock,
  input wire logic          clear,
  shift_sequencer_if.slave  bus
);

  localparam int                 c_CNT_W  = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_STEP_K = c_CNT_W'(STEP);

  state_e               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_acc, w_acc_nxt, w_step_acc;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt, w_k;
  logic [2:0]           r_op, w_op_nxt;
  logic [2*WIDTH-1:0]   r_z;
  logic                 w_unused_b;

  assign w_unused_b = ^bus.B[WIDTH-1:c_CNT_W];

  // Never take more than what is left, so the counter cannot wrap.
  assign w_k = (r_cnt < c_STEP_K) ? r_cnt : c_STEP_K;

  shift_sequencer_step #(
    .WIDTH (WIDTH),
    .KW    (c_CNT_W)
  ) u_step (
    .i_acc (r_acc),
    .i_op  (r_op),
    .i_k   (w_k),
    .o_acc (w_step_acc)
  );

  always_comb begin
    w_state_nxt = ST_IDLE;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    case (r_state)
      ST_SHIFT: begin
        w_acc_nxt   = w_step_acc;
        w_cnt_nxt   = r_cnt - w_k;
        w_state_nxt = (r_cnt == w_k) ? ST_DONE : ST_SHIFT;
      end
      default: begin
        if (bus.start) begin
          w_acc_nxt   = bus.A;
          w_cnt_nxt   = bus.B[c_CNT_W-1:0];
          w_op_nxt    = bus.op;
          w_state_nxt = ((bus.B[c_CNT_W-1:0] == '0) || is_reserved(bus.op))
                        ? ST_DONE : ST_SHIFT;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
      r_z     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      if (w_state_nxt == ST_DONE) begin
        r_z <= {{WIDTH{1'b0}}, w_acc_nxt};
      end
    end
  end

  assign bus.busy = (r_state == ST_SHIFT);
  assign bus.done = (r_state == ST_DONE);
  assign bus.Z    = r_z;

endmodule

`default_nettype wire
